fm_da_out: RTL and testbench
============================

FM_DA_OUT -- requirements
Module: fm_da_out

Interface
REQ-001 Parameter DEC_LOG2, default 2, log2 of the decimation factor DEC_N (DEC_N = 2^DEC_LOG2).
REQ-002 Parameter DC_K, default 8, DC-tracker leak shift.
REQ-003 Parameter TRUNC_LSB, default 12, LSBs dropped from the DC-corrected sample.
REQ-004 Parameter WARMUP, default 16, number of decimated outputs forced to midscale after reset.
REQ-005 Port clk1 in 1: the only clock; all state changes on the rising edge. The reset is sys_rst, asynchronous, active-low, on clock clk1.
REQ-006 Port sys_rst in 1: asynchronous assert, active-low.
REQ-007 Port din in 28: signed demodulator FIR output.
REQ-008 Port din_valid in 1: din qualifier; samples are accepted on any cycle where it is high, and gaps are allowed.
REQ-009 Port gain_sel in 2: post-truncation left shift of 0 to 3, sampled in stage 3.
REQ-010 Port clip_clr in 1: synchronous clear of the clip flag and clip counter.
REQ-011 Port da_data out 14: offset-binary DA code.
REQ-012 Port da_valid out 1: one-cycle strobe marking a new da_data.
REQ-013 Port clip_flag out 1: sticky saturation indicator.
REQ-014 Port clip_cnt out 8: saturating count of clipped outputs.

Function
REQ-015 Stage 1 shall accumulate din into acc (signed, 28+DEC_LOG2 bits), with cnt counting accepted samples from 0 to DEC_N-1.
REQ-016 When din_valid=1 and cnt=DEC_N-1, stage 1 shall register dec_sum=acc+din, pulse dec_stb for one cycle, reset acc to 0, and wrap cnt to 0.
REQ-017 When din_valid=0, acc and cnt shall hold their values.
REQ-018 Stage 2, on dec_stb, shall compute avg = dec_sum >>> DEC_LOG2 (arithmetic shift) and register x = avg - dc at 29 bits signed.
REQ-019 On the same cycle, stage 2 shall update dc <= dc + ((avg - dc) >>> DC_K), using the old dc in both expressions.
REQ-020 Stage 3 shall compute y = (x >>> TRUNC_LSB) << gain_sel and saturate y to the range -8192 to +8191.
REQ-021 A value outside that range is a clip event.
REQ-022 The output register shall set da_data = saturated y + 8192 (MSB inverted), and da_valid shall pulse exactly once per dec_stb.
REQ-023 Latency: da_valid shall be high on the 3rd rising edge after the edge that samples the group-completing din_valid.
REQ-024 A state machine shall have two states, WARM and RUN, and shall enter WARM on reset.
REQ-025 In WARM, every output strobe shall drive da_data=8192 with da_valid still pulsing, the dc tracker shall keep updating, and a warm counter shall increment per output.
REQ-026 The machine shall move WARM to RUN on the WARMUP-th output strobe; RUN is terminal until reset.
REQ-027 Clip events shall be counted only in RUN.
REQ-028 On a clip event, clip_flag shall be set to 1 and clip_cnt shall increment, saturating at 255 with no wrap.
REQ-029 clip_clr=1 shall clear clip_flag and clip_cnt; if a clip event occurs in the same cycle, clip_clr wins and the event is dropped.
REQ-030 There shall be no backpressure, and any output strobe shall never be skipped or duplicated.

Reset
REQ-031 While sys_rst=0, the block shall hold acc=0, cnt=0, dec_stb=0, dc=0, x=0, state=WARM, warm counter=0, da_data=14'h2000, da_valid=0, clip_flag=0 and clip_cnt=0.
REQ-032 Reset asserted mid-group shall discard the partial accumulation, and no da_valid shall issue for that group.
REQ-033 After sys_rst releases, the first group shall begin with the first din_valid sample.

Verification
REQ-034 Reset check: with sys_rst=0, outputs shall read da_data=0x2000, da_valid=0, clip_flag=0 and clip_cnt=0.
REQ-035 Decimation/latency check: din=0 with din_valid held high shall give da_valid once every 4 cycles, first 3 cycles after the 4th sample, with da_data=8192.
REQ-036 Gain check: after 16 zero groups, one group of 4 samples of din=4096000 with gain_sel=0 shall give da_data=9192; the same group with gain_sel=3 shall give 16192.
REQ-037 Saturation check: in RUN with dc≈0 and gain_sel=3, a group of din=8192000 shall give da_data=16383, clip_flag=1 and clip_cnt=1; 300 such groups shall give clip_cnt=255.
REQ-038 Gap/clear check: with din_valid toggling 1,0,1,0…, exactly one da_valid per 4 accepted samples; clip_clr coincident with a clip shall give clip_cnt=0 and clip_flag=0 the next cycle.
REQ-039 Mid-reset check: sys_rst pulsed after 2 of 4 samples shall produce no da_valid; the next 4 samples shall give one strobe with da_data=8192 (WARM).

Source files
------------

// File: rtl/fm_da_out.sv
// fm_da_out -- FM demodulator back end driving a 14-bit offset-binary DAC.
//
// Pipeline: decimate-by-DEC_N accumulator -> DC tracker / removal ->
// truncate, gain, saturate -> output register with a warm-up state machine.
// One output strobe is produced per DEC_N accepted input samples.
//
// Handshake: din is consumed on every rising edge of clk1 where din_valid is
// high, with no backpressure. da_valid is a single-cycle strobe that qualifies
// da_data, and it is never stalled or repeated. da_data holds its value between
// strobes.
//
// Ports:
//   clk1      in   1  clock, rising edge
//   sys_rst   in   1  asynchronous reset, active low
//   din       in  28  signed demodulator FIR output
//   din_valid in   1  din qualifier, gaps allowed
//   gain_sel  in   2  left shift 0..3 applied after truncation
//   clip_clr  in   1  synchronous clear of clip_flag / clip_cnt
//   da_data   out 14  offset-binary DAC code
//   da_valid  out  1  new-sample strobe
//   clip_flag out  1  sticky saturation indicator (RUN state only)
//   clip_cnt  out  8  saturating clip counter (RUN state only)
//   dbg_run   out  1  warm-up state machine is in RUN
module fm_da_out #(
    parameter int DEC_LOG2  = 2,
    parameter int DC_K      = 8,
    parameter int TRUNC_LSB = 12,
    parameter int WARMUP    = 16
) (
    input  logic               clk1,
    input  logic               sys_rst,
    input  logic signed [27:0] din,
    input  logic               din_valid,
    input  logic [1:0]         gain_sel,
    input  logic               clip_clr,
    output logic [13:0]        da_data,
    output logic               da_valid,
    output logic               clip_flag,
    output logic [7:0]         clip_cnt,
    output logic               dbg_run
);

    localparam int AW    = 28 + DEC_LOG2;
    localparam int DEC_N = 1 << DEC_LOG2;
    localparam int WW    = $clog2(WARMUP + 1);

    typedef enum logic {WARM = 1'b0, RUN = 1'b1} state_t;

    // ---------------- stage 1: decimating accumulator ----------------
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   dec_sum;
    logic [DEC_LOG2-1:0]    cnt;
    logic                   dec_stb;

    assign acc_next = acc + AW'(din);

    always_ff @(posedge clk1 or negedge sys_rst) begin
        if (!sys_rst) begin
            acc     <= '0;
            cnt     <= '0;
            dec_sum <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= 1'b0;
            if (din_valid) begin
                if (cnt == DEC_LOG2'(DEC_N - 1)) begin
                    dec_sum <= acc_next;
                    dec_stb <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 2: DC tracking and removal ----------------
    // avg - dc is formed once and used both for the output and for the
    // leaky update, so both see the pre-update dc.
    logic signed [27:0] avg;
    logic signed [28:0] dc;
    logic signed [29:0] diff;
    logic signed [28:0] x;
    logic               x_stb;

    assign avg  = 28'(dec_sum >>> DEC_LOG2);
    assign diff = 30'(avg) - 30'(dc);

    always_ff @(posedge clk1 or negedge sys_rst) begin
        if (!sys_rst) begin
            dc    <= '0;
            x     <= '0;
            x_stb <= 1'b0;
        end else begin
            x_stb <= dec_stb;
            if (dec_stb) begin
                x  <= 29'(diff);
                dc <= 29'(30'(dc) + (diff >>> DC_K));
            end
        end
    end

    // ---------------- stage 3: truncate, gain, saturate ----------------
    logic signed [31:0] y_sh;
    logic signed [13:0] y_sat;
    logic               y_clip;
    logic               y_stb;

    assign y_sh = (32'(x) >>> TRUNC_LSB) <<< gain_sel;

    always_ff @(posedge clk1 or negedge sys_rst) begin
        if (!sys_rst) begin
            y_sat  <= '0;
            y_clip <= 1'b0;
            y_stb  <= 1'b0;
        end else begin
            y_stb <= x_stb;
            if (x_stb) begin
                if (y_sh > 32'sd8191) begin
                    y_sat  <= 14'sd8191;
                    y_clip <= 1'b1;
                end else if (y_sh < -32'sd8192) begin
                    y_sat  <= -14'sd8192;
                    y_clip <= 1'b1;
                end else begin
                    y_sat  <= 14'(y_sh);
                    y_clip <= 1'b0;
                end
            end
        end
    end

    // ---------------- output register and warm-up FSM ----------------
    state_t          state;
    logic [WW-1:0]   warm_cnt;

    always_ff @(posedge clk1 or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= WARM;
            warm_cnt  <= '0;
            da_data   <= 14'h2000;
            da_valid  <= 1'b0;
            clip_flag <= 1'b0;
            clip_cnt  <= '0;
        end else begin
            da_valid <= y_stb;
            if (y_stb) begin
                case (state)
                    WARM: begin
                        // Midscale while the DC tracker settles; the
                        // WARMUP-th forced output is the last one.
                        da_data  <= 14'h2000;
                        warm_cnt <= warm_cnt + 1'b1;
                        if (warm_cnt == WW'(WARMUP - 1))
                            state <= RUN;
                    end
                    RUN: begin
                        // Two's complement to offset binary: flip the MSB.
                        da_data <= {~y_sat[13], y_sat[12:0]};
                    end
                    default: state <= WARM;
                endcase
            end
            // A clear issued alongside a clip event discards the event.
            if (clip_clr) begin
                clip_flag <= 1'b0;
                clip_cnt  <= '0;
            end else if (y_stb && y_clip && state == RUN) begin
                clip_flag <= 1'b1;
                if (clip_cnt != 8'hFF)
                    clip_cnt <= clip_cnt + 1'b1;
            end
        end
    end

    assign dbg_run = (state == RUN);

endmodule

// File: tb/tb_fm_da_out.sv
// tb_fm_da_out -- directed self-checking bench for fm_da_out.
// Inputs change on the falling edge of clk1 and outputs are observed on the
// falling edge, half a cycle away from the active rising edge.
module tb_fm_da_out;

    logic               clk1;
    logic               sys_rst;
    logic signed [27:0] din;
    logic               din_valid;
    logic [1:0]         gain_sel;
    logic               clip_clr;
    logic [13:0]        da_data;
    logic               da_valid;
    logic               clip_flag;
    logic [7:0]         clip_cnt;
    logic               dbg_run;

    int          n_cmp;
    int          n_bad;
    int          seen_cnt;
    logic [13:0] seen_data;
    logic        obs_stb;
    logic [13:0] obs_data;

    fm_da_out dut (
        .clk1      (clk1),
        .sys_rst   (sys_rst),
        .din       (din),
        .din_valid (din_valid),
        .gain_sel  (gain_sel),
        .clip_clr  (clip_clr),
        .da_data   (da_data),
        .da_valid  (da_valid),
        .clip_flag (clip_flag),
        .clip_cnt  (clip_cnt),
        .dbg_run   (dbg_run)
    );

    // ---------------- clock ----------------
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One cycle: observe outputs at the falling edge, then drive new inputs.
    task automatic step(input logic signed [27:0] v, input logic vld, input logic clr);
        @(negedge clk1);
        obs_stb  = da_valid;
        obs_data = da_data;
        if (da_valid) begin
            seen_cnt++;
            seen_data = da_data;
        end
        din       = v;
        din_valid = vld;
        clip_clr  = clr;
    endtask

    task automatic group(input logic signed [27:0] v);
        for (int i = 0; i < 4; i++) step(v, 1'b1, 1'b0);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(28'sd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        sys_rst   = 1'b0;
        din_valid = 1'b0;
        clip_clr  = 1'b0;
        @(negedge clk1);
        check("rst_da_data", 32'(da_data), 32'h2000);
        check("rst_da_valid", 32'(da_valid), 32'd0);
        check("rst_clip_flag", 32'(clip_flag), 32'd0);
        check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
        sys_rst = 1'b1;
    endtask

    // 16 zero groups take the machine through WARM into RUN.
    task automatic warmup();
        for (int g = 0; g < 16; g++) begin
            group(28'sd0);
            flush(5);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        seen_cnt  = 0;
        seen_data = '0;
        sys_rst   = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        gain_sel  = 2'd0;
        clip_clr  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk1);
        check("reset_da_data", 32'(da_data), 32'h2000);
        check("reset_da_valid", 32'(da_valid), 32'd0);
        check("reset_clip_flag", 32'(clip_flag), 32'd0);
        check("reset_clip_cnt", 32'(clip_cnt), 32'd0);
        check("reset_state", 32'(dbg_run), 32'd0);
        sys_rst = 1'b1;

        // Decimation/latency: 16 back-to-back zero samples. The sample driven
        // on step n is taken at the following rising edge; groups end at
        // samples 3,7,11,15 and their strobes are seen on steps 7,11,15,19.
        for (int n = 0; n < 20; n++) begin
            step(28'sd0, (n < 16), 1'b0);
            check("lat_strobe", 32'(obs_stb), 32'((n >= 7) && ((n - 7) % 4 == 0)));
            if (n >= 7 && (n - 7) % 4 == 0)
                check("lat_data", 32'(obs_data), 32'd8192);
        end
        check("lat_count", 32'(seen_cnt), 32'd4);

        // 11 more zero groups: 15 outputs, still warming.
        for (int i = 0; i < 44; i++) step(28'sd0, 1'b1, 1'b0);
        flush(5);
        check("warm15_count", 32'(seen_cnt), 32'd15);
        check("warm15_state", 32'(dbg_run), 32'd0);
        // 16th output is still midscale and ends warm-up.
        group(28'sd0);
        flush(5);
        check("warm16_data", 32'(seen_data), 32'd8192);
        check("warm16_state", 32'(dbg_run), 32'd1);

        // Gain 0: avg 4096000, dc 0 -> 4096000>>>12 = 1000 -> 9192.
        seen_cnt = 0;
        group(28'sd4096000);
        flush(5);
        check("gain0_count", 32'(seen_cnt), 32'd1);
        check("gain0_data", 32'(seen_data), 32'd9192);
        check("gain0_clip", 32'(clip_flag), 32'd0);

        // Gain 3 from a fresh dc: 1000 << 3 = 8000 -> 16192.
        do_reset();
        warmup();
        gain_sel = 2'd3;
        seen_cnt = 0;
        group(28'sd4096000);
        flush(5);
        check("gain3_count", 32'(seen_cnt), 32'd1);
        check("gain3_data", 32'(seen_data), 32'd16192);
        check("gain3_clip", 32'(clip_flag), 32'd0);

        // Saturation: 8192000 -> 2000 << 3 = 16000 > 8191 -> 16383.
        do_reset();
        warmup();
        seen_cnt = 0;
        group(28'sd8192000);
        flush(5);
        check("sat_data", 32'(seen_data), 32'd16383);
        check("sat_flag", 32'(clip_flag), 32'd1);
        check("sat_cnt1", 32'(clip_cnt), 32'd1);
        // Alternating full-scale groups keep dc near zero, so each one clips
        // (negative ones land on code 0). 300 clips saturate the counter.
        for (int i = 1; i < 300; i++)
            group((i % 2 == 1) ? -28'sd8192000 : 28'sd8192000);
        flush(5);
        check("sat_strobes", 32'(seen_cnt), 32'd300);
        check("sat_cnt255", 32'(clip_cnt), 32'd255);
        check("sat_neg_data", 32'(seen_data), 32'd0);

        // Clear in the same cycle as a clip event: the clear wins.
        group(28'sd8192000);
        step(28'sd0, 1'b0, 1'b0);
        step(28'sd0, 1'b0, 1'b0);
        step(28'sd0, 1'b0, 1'b1);
        step(28'sd0, 1'b0, 1'b0);
        check("clr_strobe", 32'(obs_stb), 32'd1);
        check("clr_cnt", 32'(clip_cnt), 32'd0);
        check("clr_flag", 32'(clip_flag), 32'd0);
        group(-28'sd8192000);
        flush(5);
        check("post_clr_cnt", 32'(clip_cnt), 32'd1);
        check("post_clr_flag", 32'(clip_flag), 32'd1);
        step(28'sd0, 1'b0, 1'b1);
        step(28'sd0, 1'b0, 1'b0);
        check("plain_clr_cnt", 32'(clip_cnt), 32'd0);
        check("plain_clr_flag", 32'(clip_flag), 32'd0);

        // Gapped input: 12 accepted samples over 24 cycles -> 3 strobes.
        gain_sel = 2'd0;
        seen_cnt = 0;
        for (int i = 0; i < 24; i++) step(28'sd0, (i % 2 == 0), 1'b0);
        flush(5);
        check("gap_strobes", 32'(seen_cnt), 32'd3);

        // Mid-group reset: the partial group is discarded.
        seen_cnt = 0;
        step(28'sd4096000, 1'b1, 1'b0);
        step(28'sd4096000, 1'b1, 1'b0);
        do_reset();
        flush(6);
        check("midrst_none", 32'(seen_cnt), 32'd0);
        group(28'sd0);
        flush(5);
        check("midrst_one", 32'(seen_cnt), 32'd1);
        check("midrst_data", 32'(seen_data), 32'd8192);
        check("midrst_state", 32'(dbg_run), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
